// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  localparam int unsigned PORT_A = 0;
  localparam int unsigned PORT_B = 1;

  localparam int unsigned DEFAULT_MAX_BURST = 8;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the port
// that was not granted last wins. Output is one-hot (or zero when idle).
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // Tie-break against the most recently granted port
  always_comb begin
    pick = '0;
    if (&req) begin
      if (last == 1'(PORT_B)) pick[PORT_A] = 1'b1;
      else                    pick[PORT_B] = 1'b1;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the core (A) and
// the loader/DMA engine (B): round-robin with bounded burst lock, read
// valid tracking, core stall and a saturating stall counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic              a_stall,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  wait_cnt_a
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  owner_e          owner_q, owner_d, own_eff;
  logic            last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            a_rvalid_q, a_rvalid_d;
  logic            b_rvalid_q, b_rvalid_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]      pick;
  logic            gnt_a, gnt_b;

  rr_pick2 u_pick (
    .req  ({b_req, a_req}),
    .last (last_q),
    .pick (pick)
  );

  // Grant decision: an owner that stopped requesting is released in the
  // same cycle, then either the owner keeps the port or round-robin picks
  always_comb begin
    own_eff = owner_q;
    if (owner_q == OWN_A && !a_req) own_eff = OWN_NONE;
    if (owner_q == OWN_B && !b_req) own_eff = OWN_NONE;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (own_eff)
      OWN_A: begin
        if (b_req && burst_q == BURST_MAX) gnt_b = 1'b1;
        else                               gnt_a = 1'b1;
      end
      OWN_B: begin
        if (a_req && burst_q == BURST_MAX) gnt_a = 1'b1;
        else                               gnt_b = 1'b1;
      end
      default: begin
        gnt_a = pick[PORT_A];
        gnt_b = pick[PORT_B];
      end
    endcase
    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Ownership, burst length, read-valid and stall-counter next state
  always_comb begin
    owner_d    = own_eff;
    last_d     = last_q;
    burst_d    = (own_eff == OWN_NONE) ? '0 : burst_q;
    if (gnt_a) begin
      last_d = 1'(PORT_A);
      if (a_lock) begin
        owner_d = OWN_A;
        burst_d = (own_eff != OWN_A) ? BW'(1) :
                  (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
      end else begin
        owner_d = OWN_NONE;
        burst_d = '0;
      end
    end else if (gnt_b) begin
      last_d = 1'(PORT_B);
      if (b_lock) begin
        owner_d = OWN_B;
        burst_d = (own_eff != OWN_B) ? BW'(1) :
                  (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
      end else begin
        owner_d = OWN_NONE;
        burst_d = '0;
      end
    end
    a_rvalid_d = gnt_a & ~a_we;
    b_rvalid_d = gnt_b & ~b_we;
    wait_d     = (a_stall && wait_q != '1) ? wait_q + CNT_W'(1) : wait_q;
  end

  // Memory-side mux from the granted port, zero when idle
  always_comb begin
    mem_en    = gnt_a | gnt_b;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_a) begin
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (gnt_b) begin
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      last_q     <= 1'(PORT_B);
      burst_q    <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      wait_q     <= wait_d;
    end
  end

  assign a_gnt      = gnt_a;
  assign b_gnt      = gnt_b;
  assign a_stall    = a_req & ~gnt_a;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign rdata      = mem_rdata;
  assign wait_cnt_a = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (default parameters, and
// CNT_W=4 / MAX_BURST=31) share one directed stimulus stream; a
// behavioural model checks both every cycle, with literal expectations
// for the key scenarios.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic        a_gnt1, a_rvalid1, a_stall1, b_gnt1, b_rvalid1;
  logic        mem_en1, mem_we1;
  logic [9:0]  mem_addr1;
  logic [31:0] mem_wdata1, rdata1;
  logic [31:0] mem_rdata1 = '0;
  logic [15:0] wait_cnt_a1;

  logic        a_gnt2, a_rvalid2, a_stall2, b_gnt2, b_rvalid2;
  logic        mem_en2, mem_we2;
  logic [9:0]  mem_addr2;
  logic [31:0] mem_wdata2, rdata2;
  logic [31:0] mem_rdata2;
  logic [3:0]  wait_cnt_a2;

  assign mem_rdata2 = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_stall(a_stall1),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .wait_cnt_a(wait_cnt_a1)
  );

  dmem_arbiter #(.CNT_W(4), .MAX_BURST(31)) dut2 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_stall(a_stall2),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .rdata(rdata2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .wait_cnt_a(wait_cnt_a2)
  );

  // Single-port memory behind dut1: read data appears the cycle after
  bit [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_we1) mem[mem_addr1] <= mem_wdata1;
      else         mem_rdata1     <= mem[mem_addr1];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // owner/last/grant: 0 = none, 1 = A, 2 = B
  int        MB [2]   = '{8, 31};
  int        WMAX [2] = '{65535, 15};
  int        m_own [2], m_last [2], m_burst [2], m_wait [2];
  bit        m_rva [2], m_rvb [2];
  int        n_own [2], n_last [2], n_burst [2], n_wait [2];
  bit        n_rva [2], n_rvb [2];
  bit [31:0] m_mem [0:1023];
  int        m_rdaddr, n_rdaddr;
  bit        n_wr;
  int        n_wa;
  bit [31:0] n_wd;

  function automatic int arb(input bit ar, input bit br, input int own,
                             input int last, input int burst, input int mb);
    if (own == 1 && ar) return (br && burst == mb) ? 2 : 1;
    if (own == 2 && br) return (ar && burst == mb) ? 1 : 2;
    if (ar && br) return (last == 1) ? 2 : 1;
    if (ar) return 1;
    if (br) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    n_wr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      int g, ew, lk;
      bit eag, ebg, era, erb, es;
      logic ag, bg, ra, rb, st;
      logic [15:0] wc;
      g   = rst ? 0 : arb(a_req, b_req, m_own[d], m_last[d], m_burst[d], MB[d]);
      eag = (g == 1);
      ebg = (g == 2);
      era = m_rva[d] && !rst;
      erb = m_rvb[d] && !rst;
      es  = a_req && !eag;
      ew  = rst ? 0 : m_wait[d];
      ag  = (d == 0) ? a_gnt1 : a_gnt2;
      bg  = (d == 0) ? b_gnt1 : b_gnt2;
      ra  = (d == 0) ? a_rvalid1 : a_rvalid2;
      rb  = (d == 0) ? b_rvalid1 : b_rvalid2;
      st  = (d == 0) ? a_stall1 : a_stall2;
      wc  = (d == 0) ? wait_cnt_a1 : {12'b0, wait_cnt_a2};
      chk($sformatf("m%0d_a_gnt", d), ag, eag);
      chk($sformatf("m%0d_b_gnt", d), bg, ebg);
      chk($sformatf("m%0d_a_rvalid", d), ra, era);
      chk($sformatf("m%0d_b_rvalid", d), rb, erb);
      chk($sformatf("m%0d_a_stall", d), st, es);
      chk($sformatf("m%0d_wait_cnt", d), wc, ew);
      if (d == 0) begin
        chk("m0_mem_en", mem_en1, eag | ebg);
        chk("m0_mem_we", mem_we1, eag ? a_we : ebg ? b_we : 1'b0);
        chk("m0_mem_addr", mem_addr1, eag ? a_addr : ebg ? b_addr : 10'd0);
        chk("m0_mem_wdata", mem_wdata1, eag ? a_wdata : ebg ? b_wdata : 32'd0);
        if (era || erb) chk("m0_rdata", rdata1, m_mem[m_rdaddr]);
        if (g != 0) begin
          if (eag ? a_we : b_we) begin
            n_wr = 1'b1;
            n_wa = int'(eag ? a_addr : b_addr);
            n_wd = eag ? a_wdata : b_wdata;
          end else begin
            n_rdaddr = int'(eag ? a_addr : b_addr);
          end
        end
      end
      // next model state from the grant rules
      n_last[d] = m_last[d];
      n_own[d]  = 0;
      n_burst[d] = 0;
      if (g != 0) begin
        n_last[d] = g;
        lk = (g == 1) ? int'(a_lock) : int'(b_lock);
        if (lk != 0) begin
          n_own[d]   = g;
          n_burst[d] = (m_own[d] == g) ? ((m_burst[d] < MB[d]) ? m_burst[d] + 1 : MB[d]) : 1;
        end
      end
      n_rva[d]  = eag && !a_we;
      n_rvb[d]  = ebg && !b_we;
      n_wait[d] = (es && m_wait[d] < WMAX[d]) ? m_wait[d] + 1 : m_wait[d];
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_own[d] = 0; m_last[d] = 2; m_burst[d] = 0;
        m_rva[d] = 0; m_rvb[d] = 0; m_wait[d] = 0;
      end else begin
        m_own[d] = n_own[d]; m_last[d] = n_last[d]; m_burst[d] = n_burst[d];
        m_rva[d] = n_rva[d]; m_rvb[d] = n_rvb[d]; m_wait[d] = n_wait[d];
      end
    end
    if (!rst) begin
      if (n_wr) m_mem[n_wa] = n_wd;
      m_rdaddr = n_rdaddr;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_lock = 0; b_req = 0; b_we = 0; b_lock = 0;
  endtask

  initial begin
    int bstreak, run, maxrun;
    rst = 1'b1;
    idle();
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gnt", a_gnt1, 0);
    chk("rst_mem_en", mem_en1, 0);
    chk("rst_a_rvalid", a_rvalid1, 0);
    chk("rst_wait", wait_cnt_a1, 0);
    next_cycle();
    rst = 1'b0;

    // contention, both reading, no lock: strict A,B,A,B
    for (int i = 0; i < 5; i++) begin
      a_req = (i < 4); b_req = (i < 4); a_addr = 10'd1; b_addr = 10'd2;
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("rr_a_gnt_%0d", i), a_gnt1, (i % 2) == 0);
        chk($sformatf("rr_b_gnt_%0d", i), b_gnt1, (i % 2) == 1);
        chk($sformatf("rr_a_stall_%0d", i), a_stall1, (i % 2) == 1);
      end
      chk($sformatf("rr_a_rvalid_%0d", i), a_rvalid1, (i == 1 || i == 3));
      chk($sformatf("rr_b_rvalid_%0d", i), b_rvalid1, (i == 2 || i == 4));
      next_cycle();
    end

    // write then read back address 5
    a_req = 1; a_we = 1; a_addr = 10'h005; a_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_mem_we", mem_we1, 1);
    chk("wr_mem_addr", mem_addr1, 10'h005);
    chk("wr_mem_wdata", mem_wdata1, 32'hDEADBEEF);
    next_cycle();
    a_we = 0;
    @(negedge clk);
    chk("rd_mem_en", mem_en1, 1);
    chk("rd_mem_we", mem_we1, 0);
    next_cycle();
    a_req = 0;
    @(negedge clk);
    chk("rd_a_rvalid", a_rvalid1, 1);
    chk("rd_rdata", rdata1, 32'hDEADBEEF);
    next_cycle();

    // B locked burst, A joins at cycle 3
    bstreak = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 20; i++) begin
      b_req = 1; b_lock = 1; b_we = 1; b_addr = 10'(i + 16); b_wdata = 32'(i * 3 + 1);
      a_req = (i >= 3); a_we = 0; a_addr = 10'd7;
      @(negedge clk);
      if (b_gnt1 && bstreak == i) bstreak++;
      run = a_stall1 ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (i == 8) begin
        chk("burst_handover_a", a_gnt1, 1);
        chk("burst_dut2_no_handover", a_gnt2, 0);
      end
      if (i == 9) chk("burst_b_regain", b_gnt1, 1);
      next_cycle();
    end
    chk("burst_b_streak", bstreak, 8);
    chk("burst_a_max_wait", maxrun, 8);
    idle();
    @(negedge clk);
    next_cycle();

    // lock dropped mid-burst while A waits
    for (int i = 0; i < 5; i++) begin
      b_req = (i < 4); b_lock = (i < 2); b_we = 0; b_addr = 10'd3;
      a_req = (i >= 1 && i < 4); a_we = 0; a_addr = 10'd5;
      @(negedge clk);
      if (i == 2) chk("drop_last_b", b_gnt1, 1);
      if (i == 3) chk("drop_a_next", a_gnt1, 1);
      next_cycle();
    end
    idle();

    // reset during a granted read
    a_req = 1; a_we = 0; a_addr = 10'd5;
    @(negedge clk);
    chk("rstrd_gnt", a_gnt1, 1);
    #1;
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk("rstrd_no_rvalid", a_rvalid1, 0);
    chk("rstrd_mem_en", mem_en1, 0);
    chk("rstrd_gnt_b", b_gnt1, 0);
    chk("rstrd_stall", a_stall1, 0);
    chk("rstrd_wait1", wait_cnt_a1, 0);
    chk("rstrd_wait2", wait_cnt_a2, 0);
    next_cycle();
    rst = 1'b0;

    // long stall with B locked: 4-bit counter saturates at 15
    for (int i = 0; i < 21; i++) begin
      b_req = 1; b_lock = 1; b_we = 1; b_addr = 10'd40; b_wdata = 32'h0000_1234;
      a_req = (i >= 1); a_we = 0; a_addr = 10'd5;
      @(negedge clk);
      if (i == 15) chk("sat_wait_14", wait_cnt_a2, 4'd14);
      if (i == 20) chk("sat_wait_15", wait_cnt_a2, 4'd15);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("sat_hold_15", wait_cnt_a2, 4'd15);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory between the core load/store path (port A) and a program-loader/DMA engine (port B).
- Round-robin grant with optional burst lock; the burst length is bounded so neither requester starves.
- Tracks outstanding reads and returns data with a one-cycle valid strobe.
- Provides a stall for the core and a saturating wait-cycle counter.

Parameters:
- ADDR_W, 10: word-address width.
- DATA_W, 32: data width.
- MAX_BURST, 8: maximum consecutive locked grants while the other port is requesting (≥1).
- CNT_W, 16: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  core access request
- a_we  in  1  1 = write, 0 = read
- a_lock  in  1  request to keep ownership for the next access
- a_addr  in  ADDR_W  word address
- a_wdata  in  DATA_W  write data
- a_gnt  out  1  access accepted this cycle
- a_rvalid  out  1  read data valid on rdata
- a_stall  out  1  a_req & ~a_gnt
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid: same as the A-side equivalents, for port B
- rdata  out  DATA_W  shared read-return bus (equals mem_rdata)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after an enabled read
- wait_cnt_a  out  CNT_W  saturating count of a_stall cycles

Behaviour:
- Grant is combinational in the request cycle; at most one of a_gnt/b_gnt per cycle. mem_en = a_gnt | b_gnt. mem_we/addr/wdata are muxed from the granted port; when neither port is granted, they are 0.
- Requesters hold req, we, addr and wdata stable until gnt. A write completes at gnt; no rvalid is generated.
- A read granted in cycle N gives x_rvalid = 1 in cycle N+1 (registered). rdata is mem_rdata in that cycle.
- Port state: registers last (the last granted port), owner (NONE/A/B) and burst_cnt (0..MAX_BURST).
- Arbitration order:
  1. If owner = X and x_req = 1: grant X, unless the other port requests and burst_cnt = MAX_BURST. In that case grant the other port, clear owner and reset burst_cnt to 0.
  2. If owner = X and x_req = 0: owner → NONE and arbitrate normally in the same cycle.
  3. If owner = NONE and one port requests: grant it.
  4. If owner = NONE and both ports request: grant the port ≠ last.
- On each grant to X:
  - last ← X.
  - If x_lock = 1: owner ← X, and burst_cnt ← burst_cnt+1 (saturating at MAX_BURST) if owner was already X, else 1.
  - If x_lock = 0: owner ← NONE, burst_cnt ← 0.
- A forced handover grant to the other port obeys the lock rule on that grant.
- wait_cnt_a increments each cycle a_stall = 1 and saturates at all-ones; it never wraps.
- Reset (asynchronous, any cycle): gnt = 0, rvalid = 0, mem_en = 0, owner = NONE, last = B (A wins the first tie), burst_cnt = 0, wait_cnt_a = 0. A read granted in the cycle reset asserts produces no rvalid.
- Simultaneous request and lock drop: the lock bit is sampled only on grant cycles. Dropping x_lock on a granted cycle releases ownership after that access.
- MAX_BURST = 1 behaves as strict alternation under contention.

Decomposition:
- Package dmem_arb_pkg holds:
  - owner encoding: OWN_NONE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10
  - port index constants: PORT_A = 0, PORT_B = 1
  - default MAX_BURST
- Sub-module rr_pick2: combinational 2-way round-robin picker (inputs req[1:0] and last; output one-hot pick).
- Owner, burst and rvalid registers stay in dmem_arbiter.

Test Plan:
- Reset, then a_req = b_req = 1 with both reads, no lock, for 4 cycles → grants alternate A, B, A, B; a_rvalid/b_rvalid are high in the respective following cycles; a_stall is 1 on the B cycles.
- A write then a read to address 0x05 with data 0xDEADBEEF, B idle → mem_we = 1 with addr 5 in cycle 0; mem_en read in cycle 1; a_rvalid = 1 with rdata = 0xDEADBEEF in cycle 2.
- B asserts b_lock with b_req for 20 cycles, A requests from cycle 3, MAX_BURST = 8 → B gets 8 consecutive grants, then A gets 1 grant; B regains the lock afterwards; A never waits more than 8 cycles.
- b_lock drops mid-burst while A requests → A is granted the cycle after B's last locked access, and owner → NONE.
- Assert rst in the same cycle as a granted read → no a_rvalid on the next cycle; all outputs are 0, and wait_cnt_a = 0.
- CNT_W = 4, hold a_stall high for 20 cycles (B locked, MAX_BURST = 31) → wait_cnt_a reaches 15 and stays at 15.
